phy_tx_sched: RTL and testbench

Transmit scheduler that sits in front of `phy_tx` in the `clk_2f` domain. It brings the link up with a training sequence. It then shares the two PHY byte inputs (`data_in_0/valid_data_in_0`, `data_in_1/valid_data_in_1`) among four byte requesters using a two-grant round-robin arbiter. Outputs are registered and connect directly to the `phy_tx` inputs.

---
 rtl/phy_tx_sched_if.sv | 12 +
 rtl/phy_tx_sched.sv | 164 ++++++++++++++++
 tb/tb_phy_tx_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_sched_if.sv
// Requester-side bus of phy_tx_sched: four byte requesters and their accept strobes.
interface phy_tx_sched_if;
  localparam int unsigned NREQ = 4;
  localparam int unsigned BW   = 8;

  logic [NREQ-1:0]    req;
  logic [NREQ*BW-1:0] data_req;
  logic [NREQ-1:0]    grant;

  modport master (output req, output data_req, input grant);
  modport slave  (input req, input data_req, output grant);
endinterface

// File: rtl/phy_tx_sched.sv
// Link bring-up (training) plus two-grant round-robin sharing of the two phy_tx byte lanes
// among four byte requesters; lane outputs are registered.
module phy_tx_sched #(
  parameter int unsigned INIT_WORDS   = 4,
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter logic [7:0]  COM          = 8'hBC
) (
  input  logic          clk_2f,
  input  logic          reset_L,
  input  logic          link_en,
  phy_tx_sched_if.slave rq,
  output logic [7:0]    data_out_0,
  output logic [7:0]    data_out_1,
  output logic          valid_out_0,
  output logic          valid_out_1,
  output logic [1:0]    state
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned BW   = 8;
  localparam int unsigned TW   = (INIT_WORDS   > 1) ? $clog2(INIT_WORDS)   : 1;
  localparam int unsigned IW   = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(INIT_WORDS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(IDLE_TIMEOUT - 1);

  localparam logic [1:0] S_RESET  = 2'd0;
  localparam logic [1:0] S_TRAIN  = 2'd1;
  localparam logic [1:0] S_IDLE   = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  logic [1:0]    state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [IW-1:0] icnt, icnt_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [7:0]    d0_nxt, d1_nxt;
  logic          v0_nxt, v1_nxt;

  logic            arb_en;
  logic [NREQ-1:0] grant_c;
  logic            found0, found1;
  logic [1:0]      w0, w1, idx;
  logic [BW-1:0]   byte0, byte1;

  // Round-robin search from ptr: first hit takes lane 0, second hit takes lane 1.
  always_comb begin
    arb_en  = (state == S_ACTIVE) && link_en;
    grant_c = '0;
    found0  = 1'b0;
    found1  = 1'b0;
    w0      = '0;
    w1      = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (arb_en && rq.req[idx]) begin
        if (!found0) begin
          found0       = 1'b1;
          w0           = idx;
          grant_c[idx] = 1'b1;
        end else if (!found1) begin
          found1       = 1'b1;
          w1           = idx;
          grant_c[idx] = 1'b1;
        end
      end
    end
  end

  assign rq.grant = grant_c;
  assign byte0    = rq.data_req[{w0, 3'b000} +: BW];
  assign byte1    = rq.data_req[{w1, 3'b000} +: BW];

  // Next state, counters, pointer and lane register loads.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    icnt_nxt  = icnt;
    ptr_nxt   = ptr;
    d0_nxt    = '0;
    d1_nxt    = '0;
    v0_nxt    = 1'b0;
    v1_nxt    = 1'b0;

    case (state)
      S_RESET: begin
        tcnt_nxt = '0;
        icnt_nxt = '0;
        if (link_en) state_nxt = S_TRAIN;
      end
      S_TRAIN: begin
        d0_nxt = COM;
        d1_nxt = COM;
        v0_nxt = 1'b1;
        v1_nxt = 1'b1;
        if (tcnt == T_LAST) begin
          state_nxt = S_IDLE;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      S_IDLE: begin
        if (|rq.req) begin
          state_nxt = S_ACTIVE;
          icnt_nxt  = '0;
        end
      end
      default: begin
        if (found0) begin
          d0_nxt = byte0;
          v0_nxt = 1'b1;
        end
        if (found1) begin
          d1_nxt  = byte1;
          v1_nxt  = 1'b1;
          ptr_nxt = w1 + 2'd1;
        end else if (found0) begin
          ptr_nxt = w0 + 2'd1;
        end
        if (|rq.req) begin
          icnt_nxt = '0;
        end else if (icnt == I_LAST) begin
          state_nxt = S_IDLE;
          icnt_nxt  = '0;
        end else begin
          icnt_nxt = icnt + IW'(1);
        end
      end
    endcase

    // Link disable overrides everything; ptr is deliberately retained.
    if (!link_en) begin
      state_nxt = S_RESET;
      d0_nxt    = '0;
      d1_nxt    = '0;
      v0_nxt    = 1'b0;
      v1_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= S_RESET;
      tcnt        <= '0;
      icnt        <= '0;
      ptr         <= '0;
      data_out_0  <= '0;
      data_out_1  <= '0;
      valid_out_0 <= 1'b0;
      valid_out_1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      icnt        <= icnt_nxt;
      ptr         <= ptr_nxt;
      data_out_0  <= d0_nxt;
      data_out_1  <= d1_nxt;
      valid_out_0 <= v0_nxt;
      valid_out_1 <= v1_nxt;
    end
  end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched: training, round-robin pairing, pointer order, timeout, link drop, async reset.
module tb_phy_tx_sched;

  logic        clk_2f;
  logic        reset_L;
  logic        link_en;
  logic [7:0]  data_out_0, data_out_1;
  logic        valid_out_0, valid_out_1;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  phy_tx_sched_if bus ();

  phy_tx_sched dut (
    .clk_2f      (clk_2f),
    .reset_L     (reset_L),
    .link_en     (link_en),
    .rq          (bus.slave),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .state       (state)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lanes packed as {v0,d0,v1,d1}.
  task automatic chk_out(input string tag, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
    chk(tag, 32'({valid_out_0, data_out_0, valid_out_1, data_out_1}), 32'({v0, d0, v1, d1}));
  endtask

  task automatic train_check(input string tag);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out({tag, "_com"}, 1'b1, 8'hBC, 1'b1, 8'hBC);
      chk({tag, "_state"}, 32'(state), (i < 3) ? 32'd1 : 32'd2);
      chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    end
  endtask

  initial begin
    reset_L      = 1'b0;
    link_en      = 1'b0;
    bus.req      = 4'b0000;
    bus.data_req = {8'h43, 8'h32, 8'h21, 8'h10};
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk_out("rst_out", 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    tick();
    reset_L = 1'b1;
    tick();
    chk("hold_reset_state", 32'(state), 32'd0);

    // Training with no requests.
    link_en = 1'b1;
    tick();
    chk("enter_train", 32'(state), 32'd1);
    chk_out("enter_train_out", 1'b0, 8'h00, 1'b0, 8'h00);
    train_check("train1");
    tick();
    chk("idle_state", 32'(state), 32'd2);
    chk_out("idle_out", 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk("idle_stays", 32'(state), 32'd2);

    // All four requesting: pairs {0,1},{2,3} alternate.
    bus.req = 4'b1111;
    #1;
    chk("idle_no_grant", 32'(bus.grant), 32'd0);
    tick();
    chk("active_entry", 32'(state), 32'd3);
    chk("all4_g0", 32'(bus.grant), 32'b0011);
    tick();
    chk_out("all4_o0", 1'b1, 8'h10, 1'b1, 8'h21);
    chk("all4_g1", 32'(bus.grant), 32'b1100);
    tick();
    chk_out("all4_o1", 1'b1, 8'h32, 1'b1, 8'h43);
    chk("all4_g2", 32'(bus.grant), 32'b0011);
    tick();
    chk_out("all4_o2", 1'b1, 8'h10, 1'b1, 8'h21);
    chk("all4_g3", 32'(bus.grant), 32'b1100);
    tick();
    chk_out("all4_o3", 1'b1, 8'h32, 1'b1, 8'h43);

    // ptr=0, only requester 2.
    bus.req = 4'b0100;
    #1;
    chk("single2_grant", 32'(bus.grant), 32'b0100);
    tick();
    chk_out("single2_out", 1'b1, 8'h32, 1'b0, 8'h00);

    // ptr=3: requester 0 alone moves ptr to 1.
    bus.req = 4'b0001;
    #1;
    chk("single0_grant", 32'(bus.grant), 32'b0001);
    tick();
    chk_out("single0_out", 1'b1, 8'h10, 1'b0, 8'h00);

    // ptr=1 with {3,0}: 3 on lane 0, 0 on lane 1.
    bus.req = 4'b1001;
    #1;
    chk("wrap_grant", 32'(bus.grant), 32'b1001);
    tick();
    chk_out("wrap_out", 1'b1, 8'h43, 1'b1, 8'h10);

    // Idle timeout after exactly 8 request-free cycles.
    bus.req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("timeout_state", 32'(state), (i == 7) ? 32'd2 : 32'd3);
    end
    chk_out("timeout_out", 1'b0, 8'h00, 1'b0, 8'h00);

    // Request on the cycle the timeout would expire keeps ACTIVE.
    bus.req = 4'b0001;
    tick();
    chk("reenter_active", 32'(state), 32'd3);
    tick();
    bus.req = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_expiry_state", 32'(state), 32'd3);
    bus.req = 4'b0100;
    #1;
    chk("late_req_grant", 32'(bus.grant), 32'b0100);
    tick();
    chk("late_req_state", 32'(state), 32'd3);
    chk_out("late_req_out", 1'b1, 8'h32, 1'b0, 8'h00);
    bus.req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("timeout2_state", 32'(state), (i == 7) ? 32'd2 : 32'd3);
    end

    // link_en drop while granting; ptr survives.
    bus.req = 4'b1111;
    tick();
    chk("drop_pre_state", 32'(state), 32'd3);
    chk("drop_pre_grant", 32'(bus.grant), 32'b1001);
    tick();
    chk_out("drop_pre_out", 1'b1, 8'h43, 1'b1, 8'h10);
    chk("drop_pre_grant2", 32'(bus.grant), 32'b0110);
    link_en = 1'b0;
    #1;
    chk("drop_grant_now", 32'(bus.grant), 32'd0);
    tick();
    chk("drop_state", 32'(state), 32'd0);
    chk_out("drop_out", 1'b0, 8'h00, 1'b0, 8'h00);
    link_en = 1'b1;
    tick();
    chk("retrain_entry", 32'(state), 32'd1);
    chk_out("retrain_entry_out", 1'b0, 8'h00, 1'b0, 8'h00);
    train_check("train2");
    tick();
    chk("retrain_active", 32'(state), 32'd3);
    chk_out("retrain_idle_out", 1'b0, 8'h00, 1'b0, 8'h00);
    chk("ptr_kept_grant", 32'(bus.grant), 32'b0110);

    // Asynchronous reset mid-cycle.
    #2;
    reset_L = 1'b0;
    #1;
    chk("areset_grant", 32'(bus.grant), 32'd0);
    chk("areset_state", 32'(state), 32'd0);
    chk_out("areset_out", 1'b0, 8'h00, 1'b0, 8'h00);
    #2;
    reset_L = 1'b1;
    tick();
    chk("areset_train", 32'(state), 32'd1);
    train_check("train3");
    tick();
    chk("areset_active", 32'(state), 32'd3);
    chk("ptr_cleared_grant", 32'(bus.grant), 32'b0011);
    tick();
    chk_out("final_out", 1'b1, 8'h10, 1'b1, 8'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
